// File: rtl/mycpu_pkg.sv
// Shared execute-stage types for the multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mycpu_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MTHI  = 4'd4,
    MTLO  = 4'd5,
    MADD  = 4'd6,
    MADDU = 4'd7,
    MSUB  = 4'd8,
    MSUBU = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of shift-add multiply or restoring divide, BITS bits at a time.
// Latency: combinational.
// Backpressure: none; the owning FSM decides when the result is registered.
module muldiv_iter_step #(
  parameter int WIDTH = 32,
  parameter int BITS  = 1
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  // acc layout: multiply {partial_hi, multiplier_remaining}, divide {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     t;

  // Unrolled BITS single-bit steps; multiply consumes LSB first, divide MSB first
  always_comb begin
    p = acc_i;
    t = '0;
    for (int i = 0; i < BITS; i++) begin
      if (div_i) begin
        t = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        if (t >= {1'b0, opnd_i}) begin
          t = t - {1'b0, opnd_i};
          p = {t[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end else begin
          p = {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        end
      end else begin
        t = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd_i} : '0);
        p = {t, p[WIDTH-1:1]};
      end
    end
    acc_o = p;
  end

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle MULT/DIV unit owning HI/LO; MADD/MSUB family when MULDIV_MADD_EN is defined.
// Latency: MTHI/MTLO/undefined ops respond the cycle after accept; MULT/DIV N=WIDTH/BITS_PER_CYCLE cycles (N+1 for MADD/MSUB).
// Backpressure: req_ready only in IDLE; flush aborts an in-flight op with no write and no response.
module execute_muldiv
  import mycpu_pkg::*;
#(
  parameter int WIDTH          = MULDIV_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             resp_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_LD = CW'(N);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               qneg_q, qneg_d;   // quotient / product must be negated
  logic               rneg_q, rneg_d;   // remainder must be negated
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               resp_q, resp_d;
`ifdef MULDIV_MADD_EN
  logic               madd_q, madd_d;
  logic               msub_q, msub_d;
  logic               dec_madd, dec_msub;
`endif

  logic               dec_mul, dec_div, dec_sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Classify the incoming opcode into multiply/divide and signedness
  always_comb begin
    dec_mul = 1'b0;
    dec_div = 1'b0;
    dec_sgn = 1'b0;
`ifdef MULDIV_MADD_EN
    dec_madd = 1'b0;
    dec_msub = 1'b0;
`endif
    case (req_op)
      MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
      MULTU: dec_mul = 1'b1;
      DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
      DIVU:  dec_div = 1'b1;
`ifdef MULDIV_MADD_EN
      MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_madd = 1'b1; end
      MADDU: begin dec_mul = 1'b1; dec_madd = 1'b1; end
      MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_madd = 1'b1; dec_msub = 1'b1; end
      MSUBU: begin dec_mul = 1'b1; dec_madd = 1'b1; dec_msub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // The iterative core works on magnitudes; signs are restored on the final iteration
  assign a_neg = dec_sgn & req_a[WIDTH-1];
  assign b_neg = dec_sgn & req_b[WIDTH-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;

  muldiv_iter_step #(
    .WIDTH (WIDTH),
    .BITS  (BITS_PER_CYCLE)
  ) u_step (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  assign prod_fix = qneg_q ? -step_acc : step_acc;
  assign quo_fix  = qneg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];

  // Next-state, datapath loads and HI/LO write-back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    resp_d  = 1'b0;
`ifdef MULDIV_MADD_EN
    madd_d  = madd_q;
    msub_d  = msub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          if (req_op == MTHI) begin
            hi_d   = req_a;
            resp_d = 1'b1;
          end else if (req_op == MTLO) begin
            lo_d   = req_a;
            resp_d = 1'b1;
          end else if (dec_mul || dec_div) begin
            state_d = ST_CALC;
            cnt_d   = N_LD;
            div_d   = dec_div;
            acc_d   = {{WIDTH{1'b0}}, (dec_div ? a_mag : b_mag)};
            opnd_d  = dec_div ? b_mag : a_mag;
            // Divide by zero keeps an all-ones quotient regardless of dividend sign
            qneg_d  = dec_div ? ((a_neg ^ b_neg) & (|req_b)) : (a_neg ^ b_neg);
            rneg_d  = a_neg;
`ifdef MULDIV_MADD_EN
            madd_d  = dec_madd;
            msub_d  = dec_msub;
`endif
          end else begin
            // Unknown encodings complete as no-ops
            resp_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (div_q) begin
              lo_d    = quo_fix;
              hi_d    = rem_fix;
              resp_d  = 1'b1;
              state_d = ST_IDLE;
`ifdef MULDIV_MADD_EN
            end else if (madd_q) begin
              acc_d   = prod_fix;
              state_d = ST_ACC;
`endif
            end else begin
              {hi_d, lo_d} = prod_fix;
              resp_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
`ifdef MULDIV_MADD_EN
      ST_ACC: begin
        state_d = ST_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = msub_q ? ({hi_q, lo_q} - acc_q) : ({hi_q, lo_q} + acc_q);
          resp_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      resp_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q  <= 1'b0;
      msub_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      resp_q  <= resp_d;
`ifdef MULDIV_MADD_EN
      madd_q  <= madd_d;
      msub_q  <= msub_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = resp_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv at BITS_PER_CYCLE=1 and 4.
// Latency: checks accept-to-response edge counts.
// Backpressure: exercises flush in IDLE, flush mid-op and reset mid-op.
module tb_execute_muldiv;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid4 = 1'b0;
  logic        flush = 1'b0;
  muldiv_op_t  req_op = MULT;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;

  logic        req_ready, busy, resp_valid;
  logic [31:0] hi, lo;
  logic        req_ready4, busy4, resp_valid4;
  logic [31:0] hi4, lo4;

  int n_vec = 0;
  int n_err = 0;

  execute_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
    .resp_valid(resp_valid), .hi(hi), .lo(lo)
  );

  execute_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy4),
    .resp_valid(resp_valid4), .hi(hi4), .lo(lo4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request for a single cycle; returns just after the accept edge
  task automatic issue(input bit sel, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_op = op;
    req_a  = a;
    req_b  = b;
    if (sel) req_valid4 = 1'b1;
    else     req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
  endtask

  // Count edges after accept until resp_valid; bounded so a lost response still ends
  task automatic wait_resp(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? resp_valid4 : resp_valid) && lat <= 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit sel, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(sel, op, a, b);
    wait_resp(sel, lat);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".hi"},  64'(sel ? hi4 : hi), 64'(exp_hi));
    chk({tag, ".lo"},  64'(sel ? lo4 : lo), 64'(exp_lo));
    chk({tag, ".rdy"}, 64'(sel ? req_ready4 : req_ready), 64'd1);
  endtask

  initial begin
    int n_resp;

    // Reset state
    #12;
    chk("rst.hi",   64'(hi), 64'd0);
    chk("rst.lo",   64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.rdy", 64'(req_ready), 64'd1);

    // Signed/unsigned multiply
    run_op(0, MULT,  32'hFFFF_FFFF, 32'h2, "mult",  32, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(0, MULTU, 32'hFFFF_FFFF, 32'h2, "multu", 32, 32'h0000_0001, 32'hFFFF_FFFE);

    // Divide: sign rules, overflow, divide by zero
    run_op(0, DIV,  32'hFFFF_FFF9, 32'h2,         "div_neg", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32, 32'h0,         32'h8000_0000);
    run_op(0, DIVU, 32'd100,       32'h0,         "divu_z",  32, 32'd100,       32'hFFFF_FFFF);
    run_op(0, DIV,  32'hFFFF_FF9C, 32'h0,         "div_z",   32, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

    // MTHI responds right after the accept edge, then the pulse drops
    run_op(0, MTHI, 32'h1234, 32'h0, "mthi", 0, 32'h1234, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("mthi.pulse", 64'(resp_valid), 64'd0);

    // Flush in the accept cycle drops the request
    @(negedge clk);
    req_op = MTHI; req_a = 32'hBEEF; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flidle.resp", 64'(resp_valid), 64'd0);
    chk("flidle.hi",   64'(hi), 64'h1234);
    chk("flidle.busy", 64'(busy), 64'd0);

    // Flush mid-multiply, then an immediate DIVU
    issue(0, MULTU, 32'd3, 32'd5);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flcalc.busy", 64'(busy), 64'd0);
    chk("flcalc.rdy",  64'(req_ready), 64'd1);
    chk("flcalc.resp", 64'(resp_valid), 64'd0);
    chk("flcalc.hi",   64'(hi), 64'h1234);
    chk("flcalc.lo",   64'(lo), 64'hFFFF_FFFF);
    run_op(0, DIVU, 32'd100, 32'd7, "divu_after", 32, 32'd2, 32'd14);

    // Undefined encoding is a one-cycle no-op
    run_op(0, muldiv_op_t'(4'hC), 32'h5, 32'h6, "undef", 0, 32'd2, 32'd14);

    // Multiply-accumulate, or no-op when the feature is absent
    run_op(0, MTLO, 32'hFFFF_FFFF, 32'h0, "mtlo", 0, 32'd2, 32'hFFFF_FFFF);
    run_op(0, MTHI, 32'h0,         32'h0, "mthi0", 0, 32'h0, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
    run_op(0, MADDU, 32'd1, 32'd1, "maddu", 33, 32'h1, 32'h0);
`else
    run_op(0, MADDU, 32'd1, 32'd1, "maddu", 0, 32'h0, 32'hFFFF_FFFF);
`endif

    // Four bits per iteration
    run_op(1, MULTU, 32'd7, 32'd9, "bpc4", 8, 32'h0, 32'd63);

    // Reset in the middle of a divide
    run_op(0, MTHI, 32'hAAAA, 32'h0, "mthi_pre", 0, 32'hAAAA, lo);
    issue(0, DIV, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst.hi",   64'(hi), 64'd0);
    chk("arst.lo",   64'(lo), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n_resp = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) n_resp++;
    end
    chk("arst.noresp", 64'(n_resp), 64'd0);
    chk("arst.rdy",    64'(req_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
